// File: rtl/wt_cache_pkg.sv
// Shared types, AXI burst encodings and helpers for the I-cache refill path.
package wt_cache_pkg;

  localparam int unsigned RefillTidMaxW = 8;
  localparam int unsigned RefillCntW    = 9;
  localparam int unsigned RefillWordW   = 8;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP = 2'b10;

  // Fields are sized for the largest supported configuration; users truncate.
  typedef struct packed {
    logic                     valid;
    logic                     nc;
    logic [RefillTidMaxW-1:0] tid;
    logic [RefillCntW-1:0]    cnt;
    logic                     err;
    logic [RefillWordW-1:0]   start_word;
  } refill_slot_t;

  function automatic int unsigned beats_fn(input int unsigned line_w, input int unsigned data_w);
    return line_w / data_w;
  endfunction

endpackage

// File: rtl/icache_axi_refill_slot.sv
// One outstanding refill: tracks beat count and error, reassembles the line,
// and pulses done_o the cycle after the burst closes (slot frees on that edge).
module icache_axi_refill_slot
  import wt_cache_pkg::*;
#(
  parameter int unsigned LineWidth    = 128,
  parameter int unsigned AxiDataWidth = 64,
  parameter int unsigned TidWidth     = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    alloc_i,
  input  logic                    alloc_nc_i,
  input  logic [TidWidth-1:0]     alloc_tid_i,
  input  logic [RefillWordW-1:0]  alloc_start_i,
  input  logic                    beat_i,
  input  logic [AxiDataWidth-1:0] beat_data_i,
  input  logic                    beat_err_i,
  input  logic                    beat_last_i,
  output logic                    valid_o,
  output logic                    done_o,
  output logic [LineWidth-1:0]    data_o,
  output logic [TidWidth-1:0]     tid_o,
  output logic                    err_o
);

  localparam int unsigned Beats = beats_fn(LineWidth, AxiDataWidth);
  localparam int unsigned IdxW  = (Beats > 1) ? $clog2(Beats) : 1;

  refill_slot_t                         slot_q, slot_d;
  logic [Beats-1:0][AxiDataWidth-1:0]   buf_q, buf_d;
  logic                                 done_q, done_d;
  logic [RefillCntW-1:0]                eff_beats;
  logic [IdxW-1:0]                      widx;
  logic                                 unused_tid_hi;

  always_comb begin
    slot_d    = slot_q;
    buf_d     = buf_q;
    done_d    = 1'b0;
    eff_beats = slot_q.nc ? RefillCntW'(1) : RefillCntW'(Beats);
    // Truncation gives the modulo wrap; start_word is 0 unless bursts wrap.
    widx      = IdxW'(slot_q.cnt + RefillCntW'(slot_q.start_word));
    if (alloc_i) begin
      slot_d            = '0;
      slot_d.valid      = 1'b1;
      slot_d.nc         = alloc_nc_i;
      slot_d.tid        = RefillTidMaxW'(alloc_tid_i);
      slot_d.start_word = alloc_nc_i ? '0 : alloc_start_i;
      buf_d             = '0;
    end else if (slot_q.valid && beat_i) begin
      slot_d.err = slot_q.err | beat_err_i;
      if (slot_q.cnt < eff_beats) begin
        buf_d[widx] = beat_data_i;
        slot_d.cnt  = slot_q.cnt + RefillCntW'(1);
      end else begin
        slot_d.err = 1'b1;
      end
      if (beat_last_i) begin
        if (slot_q.cnt < eff_beats - RefillCntW'(1)) slot_d.err = 1'b1;
        slot_d.valid = 1'b0;
        done_d       = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_q <= '0;
      buf_q  <= '0;
      done_q <= 1'b0;
    end else begin
      slot_q <= slot_d;
      buf_q  <= buf_d;
      done_q <= done_d;
    end
  end

  assign valid_o       = slot_q.valid;
  assign done_o        = done_q;
  assign data_o        = buf_q;
  assign tid_o         = slot_q.tid[TidWidth-1:0];
  assign err_o         = slot_q.err;
  assign unused_tid_hi = ^slot_q.tid;

endmodule

// File: rtl/icache_axi_refill_adapter.sv
// L1I refill requests to AXI4 AR/R with NumTxn slots and out-of-order returns.
// ICACHE_REFILL_CWF_EN: cacheable fills use critical-word-first WRAP bursts.
module icache_axi_refill_adapter
  import wt_cache_pkg::*;
#(
  parameter int unsigned LineWidth    = 128,
  parameter int unsigned AxiDataWidth = 64,
  parameter int unsigned AxiAddrWidth = 64,
  parameter int unsigned AxiIdWidth   = 4,
  parameter int unsigned TidWidth     = 2,
  parameter int unsigned NumTxn       = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [AxiAddrWidth-1:0] req_paddr_i,
  input  logic                    req_nc_i,
  input  logic [TidWidth-1:0]     req_tid_i,
  output logic                    rtrn_valid_o,
  output logic [LineWidth-1:0]    rtrn_data_o,
  output logic [TidWidth-1:0]     rtrn_tid_o,
  output logic                    rtrn_err_o,
  output logic                    ar_valid_o,
  input  logic                    ar_ready_i,
  output logic [AxiAddrWidth-1:0] ar_addr_o,
  output logic [7:0]              ar_len_o,
  output logic [2:0]              ar_size_o,
  output logic [1:0]              ar_burst_o,
  output logic [AxiIdWidth-1:0]   ar_id_o,
  input  logic                    r_valid_i,
  output logic                    r_ready_o,
  input  logic [AxiDataWidth-1:0] r_data_i,
  input  logic [AxiIdWidth-1:0]   r_id_i,
  input  logic [1:0]              r_resp_i,
  input  logic                    r_last_i,
  output logic                    busy_o
);

  localparam int unsigned Beats   = beats_fn(LineWidth, AxiDataWidth);
  localparam int unsigned WordOff = $clog2(AxiDataWidth / 8);
  localparam int unsigned SlotW   = (NumTxn > 1) ? $clog2(NumTxn) : 1;
  localparam logic [AxiAddrWidth-1:0] LineMask = ~AxiAddrWidth'((LineWidth / 8) - 1);
  localparam logic [AxiAddrWidth-1:0] WordMask = ~AxiAddrWidth'((AxiDataWidth / 8) - 1);

  if (LineWidth % AxiDataWidth != 0) begin : g_chk_ratio
    $error("LineWidth must be a multiple of AxiDataWidth");
  end
  if ((1 << AxiIdWidth) < NumTxn) begin : g_chk_id
    $error("AxiIdWidth too narrow for NumTxn");
  end
  if (TidWidth > RefillTidMaxW) begin : g_chk_tid
    $error("TidWidth exceeds refill_slot_t tid field");
  end
`ifdef ICACHE_REFILL_CWF_EN
  if (Beats != 2 && Beats != 4 && Beats != 8 && Beats != 16) begin : g_chk_wrap
    $error("WRAP bursts need 2, 4, 8 or 16 beats per line");
  end
`endif

  logic [NumTxn-1:0]        slot_valid, slot_done, slot_err, slot_alloc, slot_beat;
  logic [LineWidth-1:0]     slot_data [NumTxn];
  logic [TidWidth-1:0]      slot_tid  [NumTxn];
  logic                     free_found, req_accept, id_hit, unused_resp0;
  logic [SlotW-1:0]         free_idx;
  logic [RefillWordW-1:0]   start_word;

  logic                     ar_valid_q, ar_valid_d;
  logic [AxiAddrWidth-1:0]  ar_addr_q, ar_addr_d;
  logic [7:0]               ar_len_q, ar_len_d;
  logic [1:0]               ar_burst_q, ar_burst_d;
  logic [AxiIdWidth-1:0]    ar_id_q, ar_id_d;

  // A slot returning this cycle is still held so its buffer can drive rtrn_data_o.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NumTxn - 1; i >= 0; i--) begin
      if (!slot_valid[i] && !slot_done[i]) begin
        free_found = 1'b1;
        free_idx   = SlotW'(i);
      end
    end
  end

  assign req_ready_o = free_found & (~ar_valid_q | ar_ready_i);
  assign req_accept  = req_valid_i & req_ready_o;

`ifdef ICACHE_REFILL_CWF_EN
  assign start_word = RefillWordW'((req_paddr_i >> WordOff) & AxiAddrWidth'(Beats - 1));
`else
  assign start_word = '0;
`endif

  always_comb begin
    ar_valid_d = ar_valid_q & ~ar_ready_i;
    ar_addr_d  = ar_addr_q;
    ar_len_d   = ar_len_q;
    ar_burst_d = ar_burst_q;
    ar_id_d    = ar_id_q;
    if (req_accept) begin
      ar_valid_d = 1'b1;
      ar_id_d    = AxiIdWidth'(free_idx);
      ar_burst_d = AXI_BURST_INCR;
      if (req_nc_i) begin
        ar_addr_d = req_paddr_i & WordMask;
        ar_len_d  = '0;
      end else begin
`ifdef ICACHE_REFILL_CWF_EN
        ar_addr_d  = req_paddr_i & WordMask;
        ar_burst_d = AXI_BURST_WRAP;
`else
        ar_addr_d  = req_paddr_i & LineMask;
`endif
        ar_len_d   = 8'(Beats - 1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ar_valid_q <= 1'b0;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      ar_burst_q <= '0;
      ar_id_q    <= '0;
    end else begin
      ar_valid_q <= ar_valid_d;
      ar_addr_q  <= ar_addr_d;
      ar_len_q   <= ar_len_d;
      ar_burst_q <= ar_burst_d;
      ar_id_q    <= ar_id_d;
    end
  end

  for (genvar g = 0; g < NumTxn; g++) begin : g_slot
    assign slot_alloc[g] = req_accept && (free_idx == SlotW'(g));
    assign slot_beat[g]  = r_valid_i && (r_id_i == AxiIdWidth'(g));

    icache_axi_refill_slot #(
      .LineWidth    (LineWidth),
      .AxiDataWidth (AxiDataWidth),
      .TidWidth     (TidWidth)
    ) i_slot (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .alloc_i       (slot_alloc[g]),
      .alloc_nc_i    (req_nc_i),
      .alloc_tid_i   (req_tid_i),
      .alloc_start_i (start_word),
      .beat_i        (slot_beat[g]),
      .beat_data_i   (r_data_i),
      .beat_err_i    (r_resp_i[1]),
      .beat_last_i   (r_last_i),
      .valid_o       (slot_valid[g]),
      .done_o        (slot_done[g]),
      .data_o        (slot_data[g]),
      .tid_o         (slot_tid[g]),
      .err_o         (slot_err[g])
    );
  end

  // Only one R beat per cycle, so at most one slot is done at a time.
  always_comb begin
    rtrn_valid_o = 1'b0;
    rtrn_data_o  = '0;
    rtrn_tid_o   = '0;
    rtrn_err_o   = 1'b0;
    for (int i = 0; i < NumTxn; i++) begin
      if (slot_done[i]) begin
        rtrn_valid_o = 1'b1;
        rtrn_data_o  = slot_data[i];
        rtrn_tid_o   = slot_tid[i];
        rtrn_err_o   = slot_err[i];
      end
    end
  end

  assign id_hit       = |(slot_valid & slot_beat);
  assign unused_resp0 = r_resp_i[0];

  assign ar_valid_o = ar_valid_q;
  assign ar_addr_o  = ar_addr_q;
  assign ar_len_o   = ar_len_q;
  assign ar_size_o  = 3'(WordOff);
  assign ar_burst_o = ar_burst_q;
  assign ar_id_o    = ar_id_q;
  assign r_ready_o  = 1'b1;
  assign busy_o     = (|slot_valid) | ar_valid_q;

  a_r_id_known: assert property (@(posedge clk_i) disable iff (!rst_ni) r_valid_i |-> id_hit)
    else $warning("R beat id %0h matches no open refill slot; beat dropped", r_id_i);

endmodule

// File: tb/tb_icache_axi_refill_adapter.sv
// Bench for icache_axi_refill_adapter: vector table plus hand sequences, with
// a return scoreboard checked on every rtrn_valid_o pulse.
module tb_icache_axi_refill_adapter;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         req_valid_i, req_ready_o, req_nc_i;
  logic [63:0]  req_paddr_i;
  logic [1:0]   req_tid_i;
  logic         rtrn_valid_o, rtrn_err_o;
  logic [127:0] rtrn_data_o;
  logic [1:0]   rtrn_tid_o;
  logic         ar_valid_o, ar_ready_i;
  logic [63:0]  ar_addr_o;
  logic [7:0]   ar_len_o;
  logic [2:0]   ar_size_o;
  logic [1:0]   ar_burst_o;
  logic [3:0]   ar_id_o;
  logic         r_valid_i, r_ready_o, r_last_i;
  logic [63:0]  r_data_i;
  logic [3:0]   r_id_i;
  logic [1:0]   r_resp_i;
  logic         busy_o;

  always #5 clk_i = ~clk_i;

  icache_axi_refill_adapter dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_paddr_i(req_paddr_i),
    .req_nc_i(req_nc_i), .req_tid_i(req_tid_i),
    .rtrn_valid_o(rtrn_valid_o), .rtrn_data_o(rtrn_data_o), .rtrn_tid_o(rtrn_tid_o),
    .rtrn_err_o(rtrn_err_o),
    .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i), .ar_addr_o(ar_addr_o),
    .ar_len_o(ar_len_o), .ar_size_o(ar_size_o), .ar_burst_o(ar_burst_o), .ar_id_o(ar_id_o),
    .r_valid_i(r_valid_i), .r_ready_o(r_ready_o), .r_data_i(r_data_i), .r_id_i(r_id_i),
    .r_resp_i(r_resp_i), .r_last_i(r_last_i), .busy_o(busy_o)
  );

`ifdef ICACHE_REFILL_CWF_EN
  localparam logic [1:0] CB = 2'b10;
`else
  localparam logic [1:0] CB = 2'b01;
`endif

  typedef struct {
    logic [63:0]      paddr;
    logic             nc;
    logic [1:0]       tid;
    int               nb;
    logic [2:0][63:0] d;
    logic [2:0][1:0]  resp;
    logic [63:0]      ea;
    logic [7:0]       elen;
    logic [1:0]       eburst;
    logic [127:0]     edata;
    logic             eerr;
  } vec_t;

  typedef struct {
    logic [1:0]   tid;
    logic [127:0] data;
    logic         err;
  } exp_t;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  exp_t mon_e;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [63:0] paddr, input logic nc, input logic [1:0] tid,
                              input int nb, input logic [63:0] d0, input logic [63:0] d1,
                              input logic [63:0] d2, input logic [1:0] r0, input logic [1:0] r1,
                              input logic [63:0] ea, input logic [7:0] elen, input logic [1:0] eburst,
                              input logic [127:0] edata, input logic eerr);
    vec_t v;
    v.paddr = paddr; v.nc = nc; v.tid = tid; v.nb = nb;
    v.d = {d2, d1, d0}; v.resp = {2'b00, r1, r0};
    v.ea = ea; v.elen = elen; v.eburst = eburst; v.edata = edata; v.eerr = eerr;
    return v;
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_exp(input logic [1:0] tid, input logic [127:0] data, input logic err);
    exp_t e;
    e.tid = tid; e.data = data; e.err = err;
    sb.push_back(e);
  endtask

  task automatic beat(input logic [3:0] id, input logic [63:0] data, input logic [1:0] resp,
                      input logic last);
    r_valid_i = 1'b1; r_id_i = id; r_data_i = data; r_resp_i = resp; r_last_i = last;
    step();
    r_valid_i = 1'b0; r_last_i = 1'b0; r_resp_i = 2'b00;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    req_valid_i = 1'b1; req_paddr_i = v.paddr; req_nc_i = v.nc; req_tid_i = v.tid;
    #1 chk({tag, "_req_ready"}, req_ready_o, 1'b1);
    step();
    req_valid_i = 1'b0;
    chk({tag, "_ar_valid"}, ar_valid_o, 1'b1);
    chk({tag, "_ar_addr"}, ar_addr_o, v.ea);
    chk({tag, "_ar_len"}, ar_len_o, v.elen);
    chk({tag, "_ar_burst"}, ar_burst_o, v.eburst);
    chk({tag, "_ar_size_id"}, {ar_size_o, ar_id_o}, {3'd3, 4'd0});
    ar_ready_i = 1'b1;
    step();
    ar_ready_i = 1'b0;
    for (int b = 0; b < v.nb; b++) begin
      if (b == v.nb - 1) push_exp(v.tid, v.edata, v.eerr);
      beat(4'd0, v.d[b], v.resp[b], b == v.nb - 1);
    end
    chk({tag, "_rtrn_latency"}, rtrn_valid_o, 1'b1);
    step();
    chk({tag, "_rtrn_pulse_idle"}, {rtrn_valid_o, busy_o}, 2'b00);
  endtask

  // Scoreboard side: every return pulse must match the oldest expectation.
  always @(negedge clk_i) begin
    if (rst_ni === 1'b1 && rtrn_valid_o === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: rtrn tid=%0h data=%0h with no return expected",
                 rtrn_tid_o, rtrn_data_o);
      end else begin
        mon_e = sb.pop_front();
        chk("rtrn_tid", rtrn_tid_o, mon_e.tid);
        chk("rtrn_data", rtrn_data_o, mon_e.data);
        chk("rtrn_err", rtrn_err_o, mon_e.err);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef ICACHE_REFILL_CWF_EN
    tbl[0] = mk(64'h8000_0018, 1'b0, 2'd0, 2, 64'hB, 64'hA, 64'h0, 2'b00, 2'b00,
                64'h8000_0018, 8'd1, CB, {64'hB, 64'hA}, 1'b0);
`else
    tbl[0] = mk(64'h8000_0018, 1'b0, 2'd0, 2, 64'hA, 64'hB, 64'h0, 2'b00, 2'b00,
                64'h8000_0010, 8'd1, CB, {64'hB, 64'hA}, 1'b0);
`endif
    tbl[1] = mk(64'h1004, 1'b1, 2'd1, 1, 64'hC, 64'h0, 64'h0, 2'b00, 2'b00,
                64'h1000, 8'd0, 2'b01, {64'h0, 64'hC}, 1'b0);
    tbl[2] = mk(64'h40, 1'b0, 2'd3, 2, 64'h21, 64'h22, 64'h0, 2'b00, 2'b10,
                64'h40, 8'd1, CB, {64'h22, 64'h21}, 1'b1);
    tbl[3] = mk(64'h2_0007, 1'b1, 2'd2, 1, 64'h33, 64'h0, 64'h0, 2'b11, 2'b00,
                64'h2_0000, 8'd0, 2'b01, {64'h0, 64'h33}, 1'b1);
    tbl[4] = mk(64'h100, 1'b0, 2'd1, 1, 64'h44, 64'h0, 64'h0, 2'b00, 2'b00,
                64'h100, 8'd1, CB, {64'h0, 64'h44}, 1'b1);
    tbl[5] = mk(64'h200, 1'b0, 2'd2, 3, 64'h51, 64'h52, 64'h53, 2'b00, 2'b00,
                64'h200, 8'd1, CB, {64'h52, 64'h51}, 1'b1);

    rst_ni = 1'b0;
    req_valid_i = 1'b0; req_paddr_i = '0; req_nc_i = 1'b0; req_tid_i = '0;
    ar_ready_i = 1'b0;
    r_valid_i = 1'b0; r_data_i = '0; r_id_i = '0; r_resp_i = '0; r_last_i = 1'b0;
    step();
    step();
    chk("reset_outputs", {ar_valid_o, rtrn_valid_o, rtrn_err_o, busy_o, r_ready_o}, 5'b00001);
    chk("reset_ar_payload", {ar_addr_o, ar_len_o, ar_burst_o, ar_id_o}, '0);
    chk("reset_rtrn_data", rtrn_data_o, '0);
    rst_ni = 1'b1;
    step();

    for (int i = 0; i < 6; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Two requests with AR stalled, then out-of-order completion.
    req_valid_i = 1'b1; req_paddr_i = 64'h100; req_nc_i = 1'b0; req_tid_i = 2'd1;
    step();
    req_paddr_i = 64'h200; req_tid_i = 2'd2;
    for (int c = 0; c < 3; c++) begin
      chk("stall_req_ready", req_ready_o, 1'b0);
      chk("stall_ar_hold", {ar_valid_o, ar_addr_o, ar_id_o}, {1'b1, 64'h100, 4'd0});
      step();
    end
    ar_ready_i = 1'b1;
    #1 chk("stall_release_ready", req_ready_o, 1'b1);
    step();
    req_valid_i = 1'b0;
    chk("second_ar", {ar_valid_o, ar_addr_o, ar_id_o}, {1'b1, 64'h200, 4'd1});
    step();
    ar_ready_i = 1'b0;
    chk("ar_drained", {ar_valid_o, busy_o}, 2'b01);
    req_valid_i = 1'b1; req_paddr_i = 64'h300; req_tid_i = 2'd3;
    #1 chk("full_req_ready", req_ready_o, 1'b0);
    beat(4'd1, 64'h61, 2'b00, 1'b0);
    push_exp(2'd2, {64'h62, 64'h61}, 1'b1);
    beat(4'd1, 64'h62, 2'b10, 1'b1);
    chk("ooo_rtrn_valid", rtrn_valid_o, 1'b1);
    chk("free_same_cycle_ready", req_ready_o, 1'b0);
    step();
    chk("free_next_cycle_ready", req_ready_o, 1'b1);
    step();
    req_valid_i = 1'b0;
    chk("third_ar", {ar_valid_o, ar_addr_o, ar_id_o}, {1'b1, 64'h300, 4'd1});
    ar_ready_i = 1'b1;
    step();
    ar_ready_i = 1'b0;
    beat(4'd0, 64'h11, 2'b00, 1'b0);
    beat(4'd1, 64'h71, 2'b00, 1'b0);
    push_exp(2'd1, {64'h12, 64'h11}, 1'b0);
    beat(4'd0, 64'h12, 2'b00, 1'b1);
    chk("b2b_first", rtrn_valid_o, 1'b1);
    push_exp(2'd3, {64'h72, 64'h71}, 1'b0);
    beat(4'd1, 64'h72, 2'b00, 1'b1);
    chk("b2b_second", rtrn_valid_o, 1'b1);
    step();
    chk("b2b_idle", {rtrn_valid_o, busy_o}, 2'b00);

    // Reset in the middle of a burst, then a stray beat.
    req_valid_i = 1'b1; req_paddr_i = 64'h400; req_nc_i = 1'b0; req_tid_i = 2'd2;
    step();
    req_valid_i = 1'b0; ar_ready_i = 1'b1;
    step();
    ar_ready_i = 1'b0;
    beat(4'd0, 64'h81, 2'b00, 1'b0);
    chk("pre_reset_busy", busy_o, 1'b1);
    rst_ni = 1'b0;
    #1 chk("mid_reset_outputs", {ar_valid_o, rtrn_valid_o, rtrn_err_o, busy_o}, 4'b0000);
    step();
    rst_ni = 1'b1;
    step();
    beat(4'd0, 64'h99, 2'b00, 1'b1);
    chk("stray_dropped", {rtrn_valid_o, busy_o}, 2'b00);
    step();
    chk("stray_no_late_rtrn", rtrn_valid_o, 1'b0);

    run_vec(tbl[0], "post_reset");
    step();
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/icache_axi_refill_adapter.md
Name: icache_axi_refill_adapter

Overview:
Parametrised I-cache refill adapter. It sits between the L1I$ memory-request port (paddr, nc, tid) and a flattened AXI4 read channel (AR/R). It supports NumTxn outstanding refills, one reassembly buffer per slot, arbitrary LineWidth/AxiDataWidth ratios, error reporting and out-of-order R-channel returns. Its only AXI master role is AR/R; write channels are tied off at top level.

Parameters:
LineWidth, 128, I-cache line width in bits; multiple of AxiDataWidth
AxiDataWidth, 64, AXI R data width in bits
AxiAddrWidth, 64, AXI address width
AxiIdWidth, 4, AXI ID width; 2**AxiIdWidth >= NumTxn
TidWidth, 2, cache transaction ID width
NumTxn, 2, outstanding refill slots, >=1

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  1  refill request valid
req_ready_o  out  1  request accepted when valid&ready
req_paddr_i  in  AxiAddrWidth  physical address
req_nc_i  in  1  non-cacheable single-word fetch
req_tid_i  in  TidWidth  cache transaction ID
rtrn_valid_o  out  1  one-cycle return pulse, no backpressure
rtrn_data_o  out  LineWidth  returned line/word
rtrn_tid_o  out  TidWidth  ID of returned request
rtrn_err_o  out  1  bus error on the returned transaction
ar_valid_o  out  1  AXI AR valid
ar_ready_i  in  1  AXI AR ready
ar_addr_o  out  AxiAddrWidth  AR address
ar_len_o  out  8  AR burst length minus one
ar_size_o  out  3  log2(AxiDataWidth/8)
ar_burst_o  out  2  AR burst type
ar_id_o  out  AxiIdWidth  slot index
r_valid_i  in  1  AXI R valid
r_ready_o  out  1  AXI R ready (constant 1)
r_data_i  in  AxiDataWidth  R data
r_id_i  in  AxiIdWidth  R ID
r_resp_i  in  2  R response
r_last_i  in  1  R last
busy_o  out  1  any slot valid or AR pending

Behaviour:
- Beats = LineWidth/AxiDataWidth.
- Reset values: all slots invalid, buffers 0; ar_valid_o=0, rtrn_valid_o=0, rtrn_err_o=0, busy_o=0; other outputs 0.
- req_ready_o = free slot exists & (!ar_valid_o | ar_ready_i). The lowest-index free slot is allocated. It latches tid, nc, beat counter=0, err=0.
- AR is registered and driven the cycle after acceptance. ar_valid_o holds with stable payload until ar_ready_i, as AXI requires.
- Cacheable request: addr = paddr aligned down to LineWidth/8; len = Beats-1; burst INCR.
- nc request: addr = paddr aligned down to AxiDataWidth/8; len = 0; burst INCR.
- ar_id_o = slot index, zero-extended.
- R beat with r_id_i matching a valid slot writes buffer word [counter], then counter++.
- For nc slots the single beat goes to word 0 and the other words are 0.
- Slot err |= r_resp_i[1]. r_id_i matching no valid slot: beat dropped (assertion fires).
- Beat arriving after counter reached Beats (no r_last): dropped, err set.
- r_last_i on the final beat: the next cycle rtrn_valid_o=1 with slot data, tid and err, and the slot is freed that same cycle.
- r_last_i early (counter < Beats-1, cacheable): returns with err=1.
- Latency: last R beat to rtrn_valid_o is 1 cycle. Back-to-back R bursts from different slots return on consecutive cycles.
- Simultaneous slot free and new request in the same cycle: the freed slot is not reusable until the next cycle.
- Reset mid-operation clears all slots and drops AR; the interconnect must be reset with the adapter.

Optional Feature:
ICACHE_REFILL_CWF_EN.
- Defined: cacheable requests use critical-word-first. ar_addr_o = paddr aligned to AxiDataWidth/8 and ar_burst_o = WRAP (Beats in {2,4,8,16} enforced by elaboration assertion). Beat k is written to word (start_word+k) mod Beats.
- Undefined: INCR from line base as above; WRAP is never issued.

Decomposition:
- wt_cache_pkg adds the refill_slot_t typedef (valid, nc, tid, cnt, err, start_word), the AXI_BURST_INCR/AXI_BURST_WRAP constants and a beats_fn helper.
- Sub-module icache_axi_refill_slot holds per-slot state and its buffer, and is instantiated NumTxn times. The top module holds allocation, the AR register and the return mux.

Test Plan:
- Cacheable paddr 0x8000_0018, default params → AR addr 0x8000_0010, len 1, INCR, id 0. Beats 0xA,0xB → rtrn_data {0xB,0xA}, err 0, one cycle after last.
- nc paddr 0x1004 → AR addr 0x1000, len 0. Beat 0xC → rtrn_data word0 0xC, word1 0.
- Two requests tid 1, 2 with ar_ready held low 3 cycles → AR stable and req_ready_o=0. Respond id1 before id0 → returns tid 2 then tid 1 in order of completion.
- Beat 1 with r_resp=SLVERR → rtrn_err_o=1. Third request while both slots busy → req_ready_o=0 until a slot frees.
- rst_ni low mid-burst → all outputs at reset values next cycle, busy_o=0, and a following stray R beat is dropped.
- With ICACHE_REFILL_CWF_EN, paddr 0x8000_0018 → AR addr 0x8000_0018, WRAP. Beats 0xB then 0xA → rtrn_data {0xB,0xA}.
